// File: rtl/poker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// poker_pkg : shared constants and helpers for the poker round sequencer. rev 1.0
// ---------------------------------------------------------------------------
package poker_pkg;

   typedef enum logic [0:0] {
      PLAYING = 1'b0,
      CASHOUT = 1'b1
   } game_state_t;

   localparam int DEF_NUM_ROUNDS  = 5;
   localparam int DEF_NUM_PLAYERS = 2;

   // Round names for the classic five-round configuration.
   localparam int PREFLOP = 0;
   localparam int FLOP    = 1;
   localparam int TURN    = 2;
   localparam int RIVER   = 3;
   localparam int TALLY   = 4;

   function automatic logic [3:0] seat_popcount(input logic [7:0] flags);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, flags[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seat_next_finder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seat_next_finder : first unfolded seat after from_seat (wrapping). rev 1.0
// ---------------------------------------------------------------------------
module seat_next_finder
   import poker_pkg::*;
#(
   parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
   parameter int PLAYER_W    = $clog2(NUM_PLAYERS)
) (
   input  logic [PLAYER_W-1:0]    from_seat,
   input  logic [NUM_PLAYERS-1:0] folded,
   output logic [PLAYER_W-1:0]    next_seat
);

   logic [PLAYER_W-1:0] cand;
   logic                found;

   // Nearest seat clockwise wins; falls back to from_seat if all others folded.
   always_comb begin
      next_seat = from_seat;
      cand      = '0;
      found     = 1'b0;
      for (int k = 1; k < NUM_PLAYERS; k++) begin
         cand = PLAYER_W'((int'(from_seat) + k) % NUM_PLAYERS);
         if (!found && !folded[cand]) begin
            next_seat = cand;
            found     = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/poker_round_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// poker_round_seq : betting-round, seat-turn, dealer and hand sequencer. rev 1.0
// ---------------------------------------------------------------------------
module poker_round_seq
   import poker_pkg::*;
#(
   parameter int NUM_ROUNDS  = DEF_NUM_ROUNDS,
   parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
   parameter int HAND_W      = 8,
   parameter int ROUND_W     = $clog2(NUM_ROUNDS),
   parameter int PLAYER_W    = $clog2(NUM_PLAYERS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   advance_p,
   input  logic                   fold_p,
   input  logic                   cashout_sw,
   output logic                   game_state,
   output logic [ROUND_W-1:0]     round_idx,
   output logic [PLAYER_W-1:0]    actor,
   output logic [PLAYER_W-1:0]    dealer,
   output logic [NUM_PLAYERS-1:0] folded,
   output logic [HAND_W-1:0]      hand_count,
   output logic                   hand_done_p
);

   localparam int                  ACT_W      = $clog2(NUM_PLAYERS + 1);
   localparam logic [ROUND_W-1:0]  LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
   localparam logic [PLAYER_W-1:0] LAST_SEAT  = PLAYER_W'(NUM_PLAYERS - 1);
   localparam logic [ACT_W-1:0]    ALL_SEATS  = ACT_W'(NUM_PLAYERS);

   game_state_t            state_q, state_d;
   logic [ACT_W-1:0]       acts_left, acts_d;
   logic [ROUND_W-1:0]     round_d;
   logic [PLAYER_W-1:0]    actor_d, dealer_d;
   logic [NUM_PLAYERS-1:0] folded_d;
   logic [HAND_W-1:0]      hand_d;
   logic                   done_d;

   logic [NUM_PLAYERS-1:0] fold_mask, mask_after;
   logic [ACT_W-1:0]       live_after;
   logic [PLAYER_W-1:0]    actor_next, dealer_next;
   logic [PLAYER_W-1:0]    dealer_inc, first_actor;

   // Seat picture as it will be once this cycle's fold (if any) lands.
   always_comb begin
      fold_mask         = '0;
      fold_mask[actor]  = 1'b1;
      mask_after        = fold_p ? (folded | fold_mask) : folded;
      live_after        = ALL_SEATS - ACT_W'(seat_popcount(8'(mask_after)));
      dealer_inc        = (dealer == LAST_SEAT) ? '0 : dealer + 1'b1;
      first_actor       = (dealer_inc == LAST_SEAT) ? '0 : dealer_inc + 1'b1;
   end

   seat_next_finder #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .PLAYER_W    (PLAYER_W)
   ) u_next_from_actor (
      .from_seat (actor),
      .folded    (mask_after),
      .next_seat (actor_next)
   );

   seat_next_finder #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .PLAYER_W    (PLAYER_W)
   ) u_next_from_dealer (
      .from_seat (dealer),
      .folded    (mask_after),
      .next_seat (dealer_next)
   );

   always_comb begin
      state_d  = state_q;
      round_d  = round_idx;
      actor_d  = actor;
      dealer_d = dealer;
      folded_d = folded;
      hand_d   = hand_count;
      acts_d   = acts_left;
      done_d   = 1'b0;
      case (state_q)
         PLAYING: begin
            if (round_idx == LAST_ROUND) begin
               // Cashout is only ever honoured here, on the tally acknowledge.
               if (advance_p) begin
                  hand_d   = hand_count + 1'b1;
                  done_d   = 1'b1;
                  folded_d = '0;
                  dealer_d = dealer_inc;
                  acts_d   = ALL_SEATS;
                  round_d  = '0;
                  actor_d  = first_actor;
                  if (cashout_sw) begin
                     state_d = CASHOUT;
                  end
               end
            end else if (fold_p || advance_p) begin
               folded_d = mask_after;
               acts_d   = acts_left - 1'b1;
               if (fold_p && (live_after == ACT_W'(1))) begin
                  round_d = LAST_ROUND;
                  actor_d = actor_next;
               end else if (acts_d == '0) begin
                  round_d = round_idx + 1'b1;
                  acts_d  = live_after;
                  actor_d = dealer_next;
               end else begin
                  actor_d = actor_next;
               end
            end
         end
         CASHOUT: begin
            if (!cashout_sw) begin
               state_d = PLAYING;
            end
         end
         default: state_d = PLAYING;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= PLAYING;
         round_idx   <= '0;
         actor       <= PLAYER_W'(1);
         dealer      <= '0;
         folded      <= '0;
         hand_count  <= '0;
         hand_done_p <= 1'b0;
         acts_left   <= ALL_SEATS;
      end else begin
         state_q     <= state_d;
         round_idx   <= round_d;
         actor       <= actor_d;
         dealer      <= dealer_d;
         folded      <= folded_d;
         hand_count  <= hand_d;
         hand_done_p <= done_d;
         acts_left   <= acts_d;
      end
   end

   assign game_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_poker_round_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_poker_round_seq : directed checks on 2-, 4- and 3-seat tables. rev 1.0
// ---------------------------------------------------------------------------
module tb_poker_round_seq;

   logic clk;
   logic adv, fld, cash;
   logic rst_a, rst_b, rst_c;

   logic       a_gs, a_done;
   logic [2:0] a_round;
   logic       a_actor, a_dealer;
   logic [1:0] a_folded;
   logic [7:0] a_hand;

   logic       b_gs, b_done;
   logic [2:0] b_round;
   logic [1:0] b_actor, b_dealer;
   logic [3:0] b_folded;
   logic [7:0] b_hand;

   logic       c_gs, c_done;
   logic [2:0] c_round;
   logic [1:0] c_actor, c_dealer;
   logic [2:0] c_folded;
   logic [7:0] c_hand;

   int n_checks = 0;
   int n_pass   = 0;

   poker_round_seq dut_a (
      .clk(clk), .reset_n(rst_a), .advance_p(adv), .fold_p(fld), .cashout_sw(cash),
      .game_state(a_gs), .round_idx(a_round), .actor(a_actor), .dealer(a_dealer),
      .folded(a_folded), .hand_count(a_hand), .hand_done_p(a_done)
   );

   poker_round_seq #(.NUM_PLAYERS(4)) dut_b (
      .clk(clk), .reset_n(rst_b), .advance_p(adv), .fold_p(fld), .cashout_sw(cash),
      .game_state(b_gs), .round_idx(b_round), .actor(b_actor), .dealer(b_dealer),
      .folded(b_folded), .hand_count(b_hand), .hand_done_p(b_done)
   );

   poker_round_seq #(.NUM_PLAYERS(3)) dut_c (
      .clk(clk), .reset_n(rst_c), .advance_p(adv), .fold_p(fld), .cashout_sw(cash),
      .game_state(c_gs), .round_idx(c_round), .actor(c_actor), .dealer(c_dealer),
      .folded(c_folded), .hand_count(c_hand), .hand_done_p(c_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // One clock with the given inputs; outputs are settled on return.
   task automatic step(input logic a, input logic f, input logic c);
      @(negedge clk);
      adv  = a;
      fld  = f;
      cash = c;
      @(posedge clk);
      #1;
      adv = 1'b0;
      fld = 1'b0;
   endtask

   initial begin
      adv = 0; fld = 0; cash = 0;
      rst_a = 0; rst_b = 0; rst_c = 0;
      repeat (2) @(posedge clk);
      #1;

      // ---- two seats, defaults ----
      check("a_rst_gs", a_gs, 0);
      check("a_rst_round", a_round, 0);
      check("a_rst_actor", a_actor, 1);
      check("a_rst_dealer", a_dealer, 0);
      check("a_rst_folded", a_folded, 0);
      check("a_rst_hand", a_hand, 0);
      check("a_rst_done", a_done, 0);
      @(negedge clk) rst_a = 1;

      for (int k = 1; k <= 8; k++) begin
         step(1, 0, 0);
         check($sformatf("a_round_p%0d", k), a_round, k / 2);
         check($sformatf("a_actor_p%0d", k), a_actor, (k % 2 == 1) ? 0 : 1);
      end
      step(1, 0, 0);
      check("a_tally_hand", a_hand, 1);
      check("a_tally_done", a_done, 1);
      check("a_tally_dealer", a_dealer, 1);
      check("a_tally_actor", a_actor, 0);
      check("a_tally_round", a_round, 0);
      step(0, 0, 0);
      check("a_done_drop", a_done, 0);
      check("a_hand_hold", a_hand, 1);
      step(1, 0, 0);
      check("a_p10_round", a_round, 0);
      check("a_p10_actor", a_actor, 1);

      // ---- cashout request mid-hand, then at tally ----
      repeat (3) step(1, 0, 0);
      check("a_r2_round", a_round, 2);
      check("a_r2_actor", a_actor, 0);
      step(0, 0, 1);
      check("a_mid_cash_gs", a_gs, 0);
      check("a_mid_cash_round", a_round, 2);
      repeat (4) step(1, 0, 1);
      check("a_pre_tally_round", a_round, 4);
      check("a_pre_tally_gs", a_gs, 0);
      step(1, 0, 1);
      check("a_cash_gs", a_gs, 1);
      check("a_cash_hand", a_hand, 2);
      check("a_cash_dealer", a_dealer, 0);
      check("a_cash_actor", a_actor, 1);
      check("a_cash_round", a_round, 0);
      step(1, 1, 1);
      check("a_frozen_gs", a_gs, 1);
      check("a_frozen_actor", a_actor, 1);
      check("a_frozen_folded", a_folded, 0);
      check("a_frozen_hand", a_hand, 2);
      check("a_frozen_done", a_done, 0);
      step(0, 0, 0);
      check("a_resume_gs", a_gs, 0);
      check("a_resume_round", a_round, 0);
      check("a_resume_dealer", a_dealer, 0);
      check("a_resume_actor", a_actor, 1);

      // ---- hand counter wrap ----
      @(negedge clk) rst_a = 0;
      @(negedge clk) rst_a = 1;
      for (int h = 0; h < 255; h++) repeat (9) step(1, 0, 0);
      check("a_hand_255", a_hand, 255);
      repeat (9) step(1, 0, 0);
      check("a_hand_wrap", a_hand, 0);
      check("a_wrap_done", a_done, 1);

      // ---- four seats ----
      @(negedge clk) begin rst_a = 0; rst_b = 1; end
      #1;
      check("b_rst_actor", b_actor, 1);
      step(1, 1, 0);
      check("b_both_folded", b_folded, 4'b0010);
      check("b_both_actor", b_actor, 2);
      check("b_both_round", b_round, 0);
      step(1, 0, 0);
      check("b_r0_actor3", b_actor, 3);
      step(1, 0, 0);
      check("b_r0_actor0", b_actor, 0);
      check("b_r0_round", b_round, 0);
      step(1, 0, 0);
      check("b_r1_round", b_round, 1);
      check("b_r1_actor", b_actor, 2);
      step(1, 0, 0);
      check("b_r1_actor3", b_actor, 3);
      step(1, 0, 0);
      check("b_r1_actor0", b_actor, 0);
      check("b_r1_still", b_round, 1);
      step(1, 0, 0);
      check("b_r2_round", b_round, 2);
      check("b_r2_actor", b_actor, 2);
      step(0, 1, 0);
      check("b_r2_folded", b_folded, 4'b0110);
      check("b_r2_actor", b_actor, 3);
      repeat (2) step(1, 0, 0);
      check("b_r3_round", b_round, 3);
      check("b_r3_actor", b_actor, 3);
      check("b_r3_folded", b_folded, 4'b0110);

      @(negedge clk) begin rst_b = 0; adv = 1; fld = 1; cash = 1; end
      @(posedge clk);
      #1;
      check("b_rst_gs", b_gs, 0);
      check("b_rst_round", b_round, 0);
      check("b_rst_dealer", b_dealer, 0);
      check("b_rst_actor2", b_actor, 1);
      check("b_rst_folded", b_folded, 0);
      check("b_rst_hand", b_hand, 0);
      check("b_rst_done", b_done, 0);
      @(negedge clk) begin rst_b = 1; adv = 0; fld = 0; cash = 0; end
      repeat (3) step(1, 0, 0);
      check("b_post_rst_round0", b_round, 0);
      step(1, 0, 0);
      check("b_post_rst_round1", b_round, 1);
      check("b_post_rst_actor", b_actor, 1);

      // ---- three seats: last survivor jumps to tally ----
      @(negedge clk) begin rst_b = 0; rst_c = 1; end
      repeat (3) step(1, 0, 0);
      check("c_r1_round", c_round, 1);
      check("c_r1_actor", c_actor, 1);
      step(0, 1, 0);
      check("c_fold1_folded", c_folded, 3'b010);
      check("c_fold1_actor", c_actor, 2);
      check("c_fold1_round", c_round, 1);
      step(0, 1, 0);
      check("c_fold2_round", c_round, 4);
      check("c_fold2_actor", c_actor, 0);
      check("c_fold2_folded", c_folded, 3'b110);
      step(0, 1, 0);
      check("c_tally_fold_folded", c_folded, 3'b110);
      check("c_tally_fold_round", c_round, 4);
      check("c_tally_fold_actor", c_actor, 0);
      check("c_tally_fold_hand", c_hand, 0);
      step(1, 0, 0);
      check("c_end_hand", c_hand, 1);
      check("c_end_done", c_done, 1);
      check("c_end_dealer", c_dealer, 1);
      check("c_end_actor", c_actor, 2);
      check("c_end_folded", c_folded, 0);
      check("c_end_round", c_round, 0);
      check("c_end_gs", c_gs, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
